fp_add_arbiter: RTL
===================

# fp_add_arbiter

Shares a single multicycle floating-point adder datapath and its start/done control unit between two requesters, port 0 and port 1, such as integer-pipeline FP issue and a microcode sequencer. Ties are resolved round-robin. The block sequences the adder's start/done handshake, including the required drop of start after done. It bounds each operation with a timeout and buffers one result per port behind a valid/ready response interface.

## Interface
- WIDTH, 32: operand/result width (IEEE-754 single).
- TIMEOUT, 64: maximum ISSUE cycles before an operation is aborted; must be ≥ 2.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N=0,1) operation request.
- reqN_ready  out  1  request accepted this cycle (combinational).
- reqN_a, reqN_b  in  WIDTH  operands.
- reqN_sub  in  1  1 = a−b, 0 = a+b.
- rspN_valid  out  1  result held for port N.
- rspN_ready  in  1  consumer takes result.
- rspN_data  out  WIDTH  result.
- rspN_err  out  1  result produced by timeout.
- fpa_start  out  1  adder start, level-held.
- fpa_a, fpa_b  out  WIDTH  adder operands.
- fpa_sub  out  1  adder operation select.
- fpa_done  in  1  adder done; stays high while fpa_start is high.
- fpa_result  in  WIDTH  adder result, valid while fpa_done = 1.
- busy  out  1  state ≠ IDLE.

## Operation
- The FSM has three states: IDLE, ISSUE and DRAIN.
- **Eligibility:** eligibleN = reqN_valid && !rspN_valid. Only the registered rspN_valid is used, so a slot drained this cycle is eligible next cycle.
- **Grant:** in IDLE, a single eligible port wins. If both are eligible, the port ≠ last_grant wins. reqN_ready = (state==IDLE) && winner==N.
- **Accept:** on handshake, latch a/b/sub into the operand register, set owner=N and last_grant=N, set fpa_start←1, and go to ISSUE.
- **ISSUE:**
  - fpa_a/fpa_b/fpa_sub are driven from the operand register and are stable for the whole operation.
  - cnt increments each ISSUE cycle.
  - If fpa_done=1: rsp[owner]_data←fpa_result, err←0, valid←1, fpa_start←0, go to DRAIN.
  - Else, if cnt==TIMEOUT−1: rsp[owner]_data←0, err←1, valid←1, fpa_start←0, go to DRAIN.
  - If done arrives in the same cycle as the timeout, done wins.
- **DRAIN:** fpa_start=0. Return to IDLE in the first cycle fpa_done=0 is sampled. This guarantees the adder has returned to its idle state before the next start.
- **Response:** rspN_valid holds, with data and err stable, until a cycle with rspN_ready=1, which clears it. Each port's response is independent of FSM state.
- **cnt:** cleared on accept, width clog2(TIMEOUT).
- **Reset values:** state=IDLE, last_grant=1 (port 0 wins the first tie), fpa_start=0, fpa_a=fpa_b=0, fpa_sub=0, all rspN_valid/data/err=0, busy=0, cnt=0.
- **Reset mid-operation:** everything returns to reset values immediately and the in-flight result is discarded. fpa_start drops asynchronously.

## Timing
- Acceptance at edge T (handshake sampled) gives fpa_start=1 from T.
- If fpa_done is first sampled high at edge T+k, then rspN_valid=1 and fpa_start=0 from T+k, and DRAIN begins.
- If fpa_done is already low at the next edge, IDLE is reached at T+k+1, and a new grant can occur in that cycle.
- **Back-to-back throughput:** one operation per k+2 cycles minimum.
- **Timeout:** err response is asserted after exactly TIMEOUT ISSUE cycles.
- reqN_ready is 0 in ISSUE and DRAIN regardless of reqN_valid. Requests are never dropped; they wait.
- The response slot is single-entry. A port with an unconsumed result is skipped, and the other port may be served.

## Test plan
- **Single op, port 0:** a=0x3F800000, b=0x40000000, sub=0, model adder done after 6 cycles → fpa_start held 6 cycles, then rsp0_data=0x40400000, rsp0_err=0; rsp0_valid held until rsp0_ready.
- **Tie round-robin:** both ports valid continuously, responses consumed immediately → grants alternate 0,1,0,1 starting with 0 after reset. Port 1 result for 0x40A00000 − 0x3F800000 = 0x40800000.
- **Full slot:** leave rsp0 unconsumed with req0_valid and req1_valid high → port 1 is granted next, and req0_ready stays 0 until rsp0_ready is pulsed.
- **Timeout:** TIMEOUT=8, adder never asserts done → after 8 ISSUE cycles rsp1_valid=1, rsp1_err=1, rsp1_data=0; FSM returns to IDLE.
- **Done held after start drop:** adder keeps fpa_done high 3 cycles after fpa_start falls → FSM stays in DRAIN with busy=1 and no grant until done falls.
- **Reset mid-ISSUE:** assert rst_n=0 three cycles into an op → fpa_start=0 and all rspN_valid=0 immediately. After release, the same request is re-granted to port 0.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one multicycle FP adder between two requesters,
// with start/done sequencing, per-operation timeout and a single-entry response slot per port.
module fp_add_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic             fpa_start,
  output logic [WIDTH-1:0] fpa_a,
  output logic [WIDTH-1:0] fpa_b,
  output logic             fpa_sub,
  input  logic             fpa_done,
  input  logic [WIDTH-1:0] fpa_result,
  output logic             busy
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_nx;
  logic elig0, elig1, winner, accept, tmo, fin, owner, last_grant;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] fin_data;
  assign elig0      = req0_valid && !rsp0_valid;
  assign elig1      = req1_valid && !rsp1_valid;
  assign winner     = (elig0 && elig1) ? !last_grant : elig1;
  assign req0_ready = (state == IDLE) && elig0 && !winner;
  assign req1_ready = (state == IDLE) && elig1 && winner;
  assign accept     = req0_ready || req1_ready;
  assign tmo        = cnt == CW'(TIMEOUT - 1);
  // done takes precedence over a timeout landing in the same cycle
  assign fin        = (state == ISSUE) && (fpa_done || tmo);
  assign fin_data   = fpa_done ? fpa_result : '0;
  assign busy       = state != IDLE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? ISSUE : IDLE;
      ISSUE:   state_nx = fin ? DRAIN : ISSUE;
      DRAIN:   state_nx = fpa_done ? DRAIN : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      fpa_start  <= 1'b0;
      fpa_a      <= '0;
      fpa_b      <= '0;
      fpa_sub    <= 1'b0;
      cnt        <= '0;
    end else if (accept) begin
      last_grant <= winner;
      owner      <= winner;
      fpa_start  <= 1'b1;
      fpa_a      <= winner ? req1_a : req0_a;
      fpa_b      <= winner ? req1_b : req0_b;
      fpa_sub    <= winner ? req1_sub : req0_sub;
      cnt        <= '0;
    end else if (state == ISSUE) begin
      cnt <= cnt + 1'b1;
      if (fin) fpa_start <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_data  <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      if (fin && !owner) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= fin_data;
        rsp0_err   <= !fpa_done;
      end else if (rsp0_ready) rsp0_valid <= 1'b0;
      if (fin && owner) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= fin_data;
        rsp1_err   <= !fpa_done;
      end else if (rsp1_ready) rsp1_valid <= 1'b0;
    end
  end
endmodule
